// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an accepted instruction into EXE_CMD/val1/val2 and holds it in a
// main register backed by a one-entry skid register, so EXE back-pressure never loses an entry.
module alu_issue_stage #(
  parameter int SIZE     = 32,
  parameter int COM_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          in_opcode,
  input  logic [SIZE-1:0]     in_rs_val,
  input  logic [SIZE-1:0]     in_rt_val,
  input  logic [15:0]         in_imm,
  input  logic [4:0]          in_dest,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     val1,
  output logic [SIZE-1:0]     val2,
  output logic [COM_SIZE-1:0] EXE_CMD,
  output logic [4:0]          out_dest,
  output logic                out_illegal
);

  // ALU command encoding; 0 is reserved for entries carrying an undefined opcode.
  localparam logic [COM_SIZE-1:0] EXE_ADD = COM_SIZE'(1);
  localparam logic [COM_SIZE-1:0] EXE_SUB = COM_SIZE'(2);
  localparam logic [COM_SIZE-1:0] EXE_AND = COM_SIZE'(3);
  localparam logic [COM_SIZE-1:0] EXE_OR  = COM_SIZE'(4);
  localparam logic [COM_SIZE-1:0] EXE_NOR = COM_SIZE'(5);
  localparam logic [COM_SIZE-1:0] EXE_XOR = COM_SIZE'(6);
  localparam logic [COM_SIZE-1:0] EXE_SLA = COM_SIZE'(7);
  localparam logic [COM_SIZE-1:0] EXE_SLL = COM_SIZE'(8);
  localparam logic [COM_SIZE-1:0] EXE_SRA = COM_SIZE'(9);
  localparam logic [COM_SIZE-1:0] EXE_SRL = COM_SIZE'(10);

  typedef struct packed {
    logic [COM_SIZE-1:0] cmd;
    logic [SIZE-1:0]     v1;
    logic [SIZE-1:0]     v2;
    logic [4:0]          dest;
    logic                ill;
  } entry_t;

  // Handshake: a transfer happens on a side only in a cycle where both valid and ready are
  // high at the rising edge; out_* hold steady while out_valid is high and out_ready is low.
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t new_e;
  logic   accept;
  logic   consume;

  always_comb begin
    new_e      = '0;
    new_e.dest = in_dest;
    case (in_opcode)
      6'd0:  new_e.cmd = EXE_ADD;
      6'd1:  new_e.cmd = EXE_SUB;
      6'd2:  new_e.cmd = EXE_AND;
      6'd3:  new_e.cmd = EXE_OR;
      6'd4:  new_e.cmd = EXE_NOR;
      6'd5:  new_e.cmd = EXE_XOR;
      6'd6:  new_e.cmd = EXE_SLA;
      6'd7:  new_e.cmd = EXE_SLL;
      6'd8:  new_e.cmd = EXE_SRA;
      6'd9:  new_e.cmd = EXE_SRL;
      6'd10: new_e.cmd = EXE_ADD;
      6'd11: new_e.cmd = EXE_SUB;
      default: new_e.ill = 1'b1;
    endcase
    if (in_opcode <= 6'd9) begin
      new_e.v1 = in_rs_val;
      new_e.v2 = in_rt_val;
    end else if (in_opcode <= 6'd11) begin
      new_e.v1 = in_rs_val;
      new_e.v2 = {{(SIZE-16){in_imm[15]}}, in_imm};
    end
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign consume  = main_valid_q & out_ready;

  // The skid register is only ever occupied while main is occupied.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = new_e;
        main_valid_d = 1'b1;
      end
    end else if (consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = new_e;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_e;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign val1        = main_q.v1;
  assign val2        = main_q.v2;
  assign EXE_CMD     = main_q.cmd;
  assign out_dest    = main_q.dest;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps then randomized traffic, checked against a
// two-deep FIFO reference model. Command codes ADD..SRL are 1..10, illegal entries use 0.
module tb_alu_issue_stage;

  localparam int EW = 4 + 32 + 32 + 5 + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [3:0]  EXE_CMD;
  logic [4:0]  out_dest;
  logic        out_illegal;

  logic [EW-1:0] dut_entry;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] held;
  logic          stalled;
  int            checks;
  int            errors;
  int            accepted;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready), .val1(val1), .val2(val2),
    .EXE_CMD(EXE_CMD), .out_dest(out_dest), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  assign dut_entry = {EXE_CMD, val1, val2, out_dest, out_illegal};

  function automatic logic [EW-1:0] ref_entry(input logic [5:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt, input logic [15:0] imm,
                                               input logic [4:0] dest);
    logic [3:0]  cmd_tbl [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                  4'd1, 4'd2};
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
    cmd = 4'd0; a = 32'd0; b = 32'd0; ill = 1'b0;
    if (op < 6'd10) begin
      cmd = cmd_tbl[op]; a = rs; b = rt;
    end else if (op < 6'd12) begin
      cmd = cmd_tbl[op]; a = rs; b = {{16{imm[15]}}, imm};
    end else begin
      ill = 1'b1;
    end
    return {cmd, a, b, dest, ill};
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input logic [4:0] dest);
    in_valid = v; in_opcode = op; in_rs_val = rs; in_rt_val = rt; in_imm = imm; in_dest = dest;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic acc;
    logic con;
    @(negedge clk);
    chk("out_valid", EW'(out_valid), EW'(exp_q.size() > 0));
    chk("in_ready", EW'(in_ready), EW'(exp_q.size() < 2));
    if (exp_q.size() > 0) chk("entry", dut_entry, exp_q[0]);
    if (stalled) chk("stable", dut_entry, held);
    acc     = in_valid && (exp_q.size() < 2);
    con     = (exp_q.size() > 0) && out_ready;
    stalled = (exp_q.size() > 0) && !out_ready && !flush;
    held    = dut_entry;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (con) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ref_entry(in_opcode, in_rs_val, in_rt_val, in_imm, in_dest));
        accepted++;
      end
    end
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; accepted = 0; stalled = 1'b0; held = '0;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 6'd0, 32'd0, 32'd0, 16'd0, 5'd0);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", EW'(out_valid), EW'(0));
    chk("rst_in_ready", EW'(in_ready), EW'(1));
    chk("rst_data", dut_entry, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ADD rs=5 rt=7
    out_ready = 1'b1;
    set_in(1'b1, 6'd0, 32'd5, 32'd7, 16'd0, 5'd3);
    cycle();
    in_valid = 1'b0;
    chk("t1_valid", EW'(out_valid), EW'(1));
    chk("t1_cmd", EW'(EXE_CMD), EW'(1));
    chk("t1_val1", EW'(val1), EW'(5));
    chk("t1_val2", EW'(val2), EW'(7));
    cycle();

    // ADDI with negative immediate, then SUBI
    set_in(1'b1, 6'd10, 32'h10, 32'h1234, 16'hFFFC, 5'd4);
    cycle();
    chk("t2_val2", EW'(val2), EW'(32'hFFFF_FFFC));
    chk("t2_cmd", EW'(EXE_CMD), EW'(1));
    set_in(1'b1, 6'd11, 32'h20, 32'h0, 16'h0005, 5'd5);
    cycle();
    chk("t2_subi_cmd", EW'(EXE_CMD), EW'(2));
    in_valid = 1'b0;
    cycle();

    // Back-pressure: A then B with EXE stalled
    out_ready = 1'b0;
    set_in(1'b1, 6'd2, 32'hA, 32'hA1, 16'd0, 5'd10);
    cycle();
    set_in(1'b1, 6'd3, 32'hB, 32'hB1, 16'd0, 5'd11);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("t3_in_ready", EW'(in_ready), EW'(0));
    chk("t3_hold_a", EW'(val1), EW'(32'hA));
    out_ready = 1'b1;
    cycle();
    chk("t3_b_next", EW'(val1), EW'(32'hB));
    cycle();
    chk("t3_drained", EW'({out_valid, in_ready}), EW'(2'b01));

    // Flush with skid full and a new input offered
    out_ready = 1'b0;
    set_in(1'b1, 6'd4, 32'h11, 32'h12, 16'd0, 5'd1);
    cycle();
    set_in(1'b1, 6'd5, 32'h21, 32'h22, 16'd0, 5'd2);
    cycle();
    flush = 1'b1;
    set_in(1'b1, 6'd6, 32'hC, 32'hC1, 16'd0, 5'd12);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_flush", EW'({out_valid, in_ready}), EW'(2'b01));
    out_ready = 1'b1;
    cycle();
    cycle();

    // Illegal opcode then a legal AND
    set_in(1'b1, 6'd63, 32'hDEAD, 32'hBEEF, 16'h7777, 5'd7);
    cycle();
    chk("t5_illegal", EW'({out_valid, out_illegal, EXE_CMD, val1, val2}), EW'({2'b11, 4'd0, 64'd0}));
    set_in(1'b1, 6'd2, 32'h3, 32'h5, 16'd0, 5'd8);
    cycle();
    chk("t5_legal", EW'(out_illegal), EW'(0));
    in_valid = 1'b0;
    cycle();

    // Randomized traffic with a mid-stream asynchronous reset
    accepted = 0;
    for (int i = 0; i < 20000 && accepted < 1000; i++) begin
      if (i == 1500) begin
        #1 rst = 1'b0;
        #1;
        chk("async_rst", EW'({out_valid, in_ready}), EW'(2'b01));
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
      end
      set_in($urandom_range(0, 3) != 0, 6'($urandom_range(0, 13)), $urandom, $urandom,
             16'($urandom), 5'($urandom));
      if ($urandom_range(0, 15) == 0) in_opcode = 6'($urandom_range(12, 63));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 63) == 0;
      cycle();
    end
    chk("rand_count", EW'(accepted >= 1000), EW'(1));

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    chk("final_empty", EW'({out_valid, in_ready}), EW'(2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
